riscv_id_operand_stage: RTL and testbench

- ID-stage operand resolution block. It sits directly downstream of the synchronous-read register file and consumes its read-port outputs.
- Each cycle it merges the RF read data with EX/MEM/WB bypass values. It detects load-use hazards, generates the ID stall, and drives the ID/EX pipeline register with resolved operands.
- It also compensates for RF read data going stale while ID is stalled.

---
 rtl/riscv_id_operand_stage.sv | 146 ++++++++++++++
 tb/tb_riscv_id_operand_stage.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/riscv_id_operand_stage.sv
// rtl/riscv_id_operand_stage.sv - ID operand resolution with bypass, load-use stall and ID/EX register
// Also covers RF read data that goes stale while ID is stalled, using WB-captured sticky copies.
module riscv_id_operand_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pd_stall_i,
  input  logic             pd_valid_i,
  input  logic [4:0]       pd_src1_i,
  input  logic [4:0]       pd_src2_i,
  input  logic             pd_use1_i,
  input  logic             pd_use2_i,
  input  logic [XLEN-1:0]  rf_src1_q_i,
  input  logic [XLEN-1:0]  rf_src2_q_i,
  input  logic [4:0]       ex_dst_i,
  input  logic             ex_we_i,
  input  logic             ex_is_load_i,
  input  logic [XLEN-1:0]  ex_result_i,
  input  logic [4:0]       mem_dst_i,
  input  logic             mem_we_i,
  input  logic [XLEN-1:0]  mem_result_i,
  input  logic [4:0]       wb_dst_i,
  input  logic             wb_we_i,
  input  logic [XLEN-1:0]  wb_result_i,
  input  logic             ex_stall_i,
  input  logic             flush_i,
  output logic             id_stall_o,
  output logic             ex_valid_o,
  output logic [XLEN-1:0]  ex_op1_o,
  output logic [XLEN-1:0]  ex_op2_o,
  output logic [4:0]       ex_src1_o,
  output logic [4:0]       ex_src2_o,
  output logic [CNT_W-1:0] ld_use_cnt_o
);

  logic             id_valid_q;
  logic [4:0]       id_src1_q, id_src2_q;
  logic             id_use1_q, id_use2_q;
  logic             sticky1_v_q, sticky2_v_q;
  logic [XLEN-1:0]  sticky1_d_q, sticky2_d_q;
  logic             ex_valid_q;
  logic [XLEN-1:0]  ex_op1_q, ex_op2_q;
  logic [4:0]       ex_src1_q, ex_src2_q;
  logic [CNT_W-1:0] cnt_q;

  logic             hazard;
  logic             id_stall;
  logic [XLEN-1:0]  op1_d, op2_d;

  function automatic logic [XLEN-1:0] resolve(
    input logic [4:0]      src,
    input logic            sv,
    input logic [XLEN-1:0] sd,
    input logic [XLEN-1:0] rf
  );
    if (src == 5'd0)                                     return '0;
    else if (ex_we_i && ex_dst_i == src && !ex_is_load_i) return ex_result_i;
    else if (mem_we_i && mem_dst_i == src)               return mem_result_i;
    else if (wb_we_i && wb_dst_i == src)                 return wb_result_i;
    else if (sv)                                         return sd;
    else                                                 return rf;
  endfunction

  always_comb begin
    op1_d  = resolve(id_src1_q, sticky1_v_q, sticky1_d_q, rf_src1_q_i);
    op2_d  = resolve(id_src2_q, sticky2_v_q, sticky2_d_q, rf_src2_q_i);
    hazard = id_valid_q && ex_we_i && ex_is_load_i && (ex_dst_i != 5'd0) &&
             ((id_use1_q && ex_dst_i == id_src1_q) || (id_use2_q && ex_dst_i == id_src2_q));
    id_stall = (hazard || ex_stall_i) && !flush_i;
  end

  // ID registers and sticky WB copies; the RF port only re-reads on a non-stalled capture
  always_ff @(posedge clk) begin
    if (rst) begin
      id_valid_q  <= 1'b0;
      id_src1_q   <= '0;
      id_src2_q   <= '0;
      id_use1_q   <= 1'b0;
      id_use2_q   <= 1'b0;
      sticky1_v_q <= 1'b0;
      sticky2_v_q <= 1'b0;
      sticky1_d_q <= '0;
      sticky2_d_q <= '0;
    end else begin
      if (!pd_stall_i) begin
        id_valid_q <= pd_valid_i;
        id_src1_q  <= pd_src1_i;
        id_src2_q  <= pd_src2_i;
        id_use1_q  <= pd_use1_i;
        id_use2_q  <= pd_use2_i;
      end
      if (flush_i) id_valid_q <= 1'b0;
      if (flush_i || !id_stall) begin
        sticky1_v_q <= 1'b0;
        sticky2_v_q <= 1'b0;
      end else if (id_valid_q && wb_we_i) begin
        if (wb_dst_i == id_src1_q && id_src1_q != 5'd0) begin
          sticky1_v_q <= 1'b1;
          sticky1_d_q <= wb_result_i;
        end
        if (wb_dst_i == id_src2_q && id_src2_q != 5'd0) begin
          sticky2_v_q <= 1'b1;
          sticky2_d_q <= wb_result_i;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q <= 1'b0;
      ex_op1_q   <= '0;
      ex_op2_q   <= '0;
      ex_src1_q  <= '0;
      ex_src2_q  <= '0;
      cnt_q      <= '0;
    end else begin
      if (flush_i) begin
        ex_valid_q <= 1'b0;
      end else if (ex_stall_i) begin
        ex_valid_q <= ex_valid_q;
      end else if (hazard) begin
        ex_valid_q <= 1'b0;
      end else begin
        ex_valid_q <= id_valid_q;
        ex_op1_q   <= op1_d;
        ex_op2_q   <= op2_d;
        ex_src1_q  <= id_src1_q;
        ex_src2_q  <= id_src2_q;
      end
      if (hazard && !ex_stall_i && !flush_i && cnt_q != {CNT_W{1'b1}})
        cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign id_stall_o   = id_stall;
  assign ex_valid_o   = ex_valid_q;
  assign ex_op1_o     = ex_op1_q;
  assign ex_op2_o     = ex_op2_q;
  assign ex_src1_o    = ex_src1_q;
  assign ex_src2_o    = ex_src2_q;
  assign ld_use_cnt_o = cnt_q;

endmodule

// File: tb/tb_riscv_id_operand_stage.sv
// tb/tb_riscv_id_operand_stage.sv - directed self-checking bench for riscv_id_operand_stage
module tb_riscv_id_operand_stage;
  localparam int XLEN  = 32;
  localparam int CNT_W = 2;

  logic clk = 1'b0;
  logic rst;
  logic pd_stall, pd_valid, pd_use1, pd_use2;
  logic [4:0] pd_src1, pd_src2, ex_dst, mem_dst, wb_dst;
  logic [XLEN-1:0] rf1, rf2, ex_res, mem_res, wb_res;
  logic ex_we, ex_ld, mem_we, wb_we, ex_stall, flush;
  logic id_stall, ex_valid;
  logic [XLEN-1:0] op1, op2;
  logic [4:0] esrc1, esrc2;
  logic [CNT_W-1:0] cnt;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;
  assign pd_stall = id_stall;

  riscv_id_operand_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .pd_stall_i(pd_stall), .pd_valid_i(pd_valid),
    .pd_src1_i(pd_src1), .pd_src2_i(pd_src2), .pd_use1_i(pd_use1), .pd_use2_i(pd_use2),
    .rf_src1_q_i(rf1), .rf_src2_q_i(rf2),
    .ex_dst_i(ex_dst), .ex_we_i(ex_we), .ex_is_load_i(ex_ld), .ex_result_i(ex_res),
    .mem_dst_i(mem_dst), .mem_we_i(mem_we), .mem_result_i(mem_res),
    .wb_dst_i(wb_dst), .wb_we_i(wb_we), .wb_result_i(wb_res),
    .ex_stall_i(ex_stall), .flush_i(flush),
    .id_stall_o(id_stall), .ex_valid_o(ex_valid), .ex_op1_o(op1), .ex_op2_o(op2),
    .ex_src1_o(esrc1), .ex_src2_o(esrc2), .ld_use_cnt_o(cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    pd_valid = 1'b0; pd_src1 = '0; pd_src2 = '0; pd_use1 = 1'b0; pd_use2 = 1'b0;
    rf1 = '0; rf2 = '0;
    ex_dst = '0; ex_we = 1'b0; ex_ld = 1'b0; ex_res = '0;
    mem_dst = '0; mem_we = 1'b0; mem_res = '0;
    wb_dst = '0; wb_we = 1'b0; wb_res = '0;
    ex_stall = 1'b0; flush = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    ex_res = 32'hFFFF_FFFF; mem_res = 32'hFFFF_FFFF;
    rst = 1'b1;
    step(); step();
    checks++; if ({ex_valid, op1, op2, esrc1, esrc2, cnt, id_stall} !== '0) begin errors++;
      $display("FAIL reset_outputs: got v=%b op1=%h op2=%h s1=%0d s2=%0d cnt=%0d st=%b expected all 0",
               ex_valid, op1, op2, esrc1, esrc2, cnt, id_stall); end
    rst = 1'b0;
    ex_res = '0; mem_res = '0;
  endtask

  task automatic test_capture();
    clear_inputs();
    pd_valid = 1'b1; pd_src1 = 5'd5; pd_src2 = 5'd0; pd_use1 = 1'b1; pd_use2 = 1'b1;
    rf1 = 32'h1234; rf2 = 32'h9999;
    step(); step();
    checks++; if (op1 !== 32'h1234) begin errors++; $display("FAIL capture_op1: got %h expected %h", op1, 32'h1234); end
    checks++; if (op2 !== 32'h0) begin errors++; $display("FAIL capture_op2_x0: got %h expected 0", op2); end
    checks++; if (ex_valid !== 1'b1 || esrc1 !== 5'd5) begin errors++;
      $display("FAIL capture_valid_src: got v=%b s1=%0d expected v=1 s1=5", ex_valid, esrc1); end
  endtask

  task automatic test_forward_priority();
    clear_inputs();
    pd_valid = 1'b1; pd_src1 = 5'd3; pd_use1 = 1'b1; rf1 = 32'h77;
    ex_we = 1'b1; ex_dst = 5'd3; ex_res = 32'hA;
    mem_we = 1'b1; mem_dst = 5'd3; mem_res = 32'hB;
    wb_we = 1'b1; wb_dst = 5'd3; wb_res = 32'hC;
    step(); step();
    checks++; if (op1 !== 32'hA) begin errors++; $display("FAIL fwd_ex: got %h expected %h", op1, 32'hA); end
    ex_we = 1'b0; step();
    checks++; if (op1 !== 32'hB) begin errors++; $display("FAIL fwd_mem: got %h expected %h", op1, 32'hB); end
    mem_we = 1'b0; step();
    checks++; if (op1 !== 32'hC) begin errors++; $display("FAIL fwd_wb: got %h expected %h", op1, 32'hC); end
    wb_we = 1'b0; step();
    checks++; if (op1 !== 32'h77) begin errors++; $display("FAIL fwd_rf: got %h expected %h", op1, 32'h77); end
  endtask

  task automatic test_load_use();
    clear_inputs();
    pd_valid = 1'b1; pd_src1 = 5'd7; pd_use1 = 1'b1;
    step();
    ex_we = 1'b1; ex_ld = 1'b1; ex_dst = 5'd7; ex_res = 32'hDEAD;
    #1;
    checks++; if (id_stall !== 1'b1) begin errors++; $display("FAIL ld_use_stall: got %b expected 1", id_stall); end
    step();
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL ld_use_bubble: got %b expected 0", ex_valid); end
    checks++; if (cnt !== 2'd1) begin errors++; $display("FAIL ld_use_cnt: got %0d expected 1", cnt); end
    ex_we = 1'b0; ex_ld = 1'b0; mem_we = 1'b1; mem_dst = 5'd7; mem_res = 32'hBEEF;
    #1;
    checks++; if (id_stall !== 1'b0) begin errors++; $display("FAIL ld_use_release: got %b expected 0", id_stall); end
    step();
    checks++; if (op1 !== 32'hBEEF || ex_valid !== 1'b1) begin errors++;
      $display("FAIL ld_use_mem_fwd: got op1=%h v=%b expected op1=beef v=1", op1, ex_valid); end
  endtask

  task automatic test_sticky();
    clear_inputs();
    pd_valid = 1'b1; pd_src2 = 5'd9; pd_use2 = 1'b1; rf2 = 32'h11;
    step(); step();
    checks++; if (op2 !== 32'h11) begin errors++; $display("FAIL sticky_pre: got %h expected 11", op2); end
    ex_stall = 1'b1;
    #1;
    checks++; if (id_stall !== 1'b1) begin errors++; $display("FAIL sticky_stall: got %b expected 1", id_stall); end
    wb_we = 1'b1; wb_dst = 5'd9; wb_res = 32'h55;
    step();
    checks++; if (op2 !== 32'h11) begin errors++; $display("FAIL sticky_ex_hold: got %h expected 11", op2); end
    wb_we = 1'b0;
    step(); step();
    ex_stall = 1'b0;
    step();
    checks++; if (op2 !== 32'h55) begin errors++; $display("FAIL sticky_release: got %h expected 55", op2); end
    step();
    checks++; if (op2 !== 32'h11) begin errors++; $display("FAIL sticky_cleared: got %h expected 11", op2); end
  endtask

  task automatic test_flush();
    clear_inputs();
    pd_valid = 1'b1; pd_src1 = 5'd7; pd_use1 = 1'b1; rf1 = 32'h3333;
    step();
    ex_stall = 1'b1; wb_we = 1'b1; wb_dst = 5'd7; wb_res = 32'h99;
    step();
    wb_we = 1'b0; flush = 1'b1; pd_valid = 1'b0;
    ex_we = 1'b1; ex_ld = 1'b1; ex_dst = 5'd7;
    #1;
    checks++; if (id_stall !== 1'b0) begin errors++; $display("FAIL flush_no_stall: got %b expected 0", id_stall); end
    step();
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL flush_ex_valid: got %b expected 0", ex_valid); end
    checks++; if (cnt !== 2'd1) begin errors++; $display("FAIL flush_cnt: got %0d expected 1", cnt); end
    flush = 1'b0; ex_stall = 1'b0; ex_we = 1'b0; ex_ld = 1'b0; pd_valid = 1'b1;
    step();
    checks++; if (op1 !== 32'h3333 || ex_valid !== 1'b0) begin errors++;
      $display("FAIL flush_sticky_idvalid: got op1=%h v=%b expected op1=3333 v=0", op1, ex_valid); end
    step();
    checks++; if (ex_valid !== 1'b1) begin errors++; $display("FAIL flush_recapture: got %b expected 1", ex_valid); end
  endtask

  task automatic test_zero_reg();
    clear_inputs();
    pd_valid = 1'b1; pd_use1 = 1'b1; pd_use2 = 1'b1; rf1 = 32'hFFFF; rf2 = 32'hFFFF;
    ex_we = 1'b1; ex_res = 32'h1; mem_we = 1'b1; mem_res = 32'h2; wb_we = 1'b1; wb_res = 32'h3;
    step(); step();
    checks++; if (op1 !== 32'h0 || op2 !== 32'h0) begin errors++;
      $display("FAIL zero_no_fwd: got op1=%h op2=%h expected 0 0", op1, op2); end
    ex_ld = 1'b1;
    #1;
    checks++; if (id_stall !== 1'b0) begin errors++; $display("FAIL zero_load_stall: got %b expected 0", id_stall); end
    step();
    checks++; if (cnt !== 2'd1 || ex_valid !== 1'b1) begin errors++;
      $display("FAIL zero_load_cnt: got cnt=%0d v=%b expected cnt=1 v=1", cnt, ex_valid); end
  endtask

  task automatic test_saturation();
    clear_inputs();
    pd_valid = 1'b1; pd_src2 = 5'd4; pd_use2 = 1'b1;
    step();
    ex_we = 1'b1; ex_ld = 1'b1; ex_dst = 5'd4; ex_stall = 1'b1;
    step();
    checks++; if (cnt !== 2'd1) begin errors++; $display("FAIL hazard_exstall_cnt: got %0d expected 1", cnt); end
    ex_stall = 1'b0;
    step(); step();
    checks++; if (cnt !== 2'd3) begin errors++; $display("FAIL cnt_reach_max: got %0d expected 3", cnt); end
    step(); step();
    checks++; if (cnt !== 2'd3) begin errors++; $display("FAIL cnt_saturate: got %0d expected 3", cnt); end
  endtask

  initial begin
    test_reset();
    test_capture();
    test_forward_priority();
    test_load_use();
    test_sticky();
    test_flush();
    test_zero_reg();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
